mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the core's single memory port between instruction fetch and the load/store path driven by the control unit's load/store decode. Runs a request/acknowledge handshake to memory, returns read data to the winning requester, and drives per-requester stall lines. Data accesses have priority, and a bounded-streak rule guarantees fetch progress. Sits between the fetch/memory pipeline stages and the external memory interface.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DM_STREAK, 4, max consecutive data grants while fetch is waiting (≥1)

- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_valid
- if_addr  in  ADDR_W  fetch address; stable while if_req
- if_rdata  out  DATA_W  fetch data; meaningful only when if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request; held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data; meaningful only when dm_valid
- dm_valid  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  write enable to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_ack  in  1  memory accept/complete; sampled only while mem_req=1
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- stall_if  out  1  if_req & ~if_valid (combinational)
- stall_dm  out  1  dm_req & ~dm_valid (combinational)

## Operation
- FSM has four states.
  - IDLE: no memory request outstanding.
  - BUSY_IF: fetch transaction in flight.
  - BUSY_DM: data transaction in flight.
  - DONE: completion cycle.
- Transitions:
  - IDLE → BUSY_DM or BUSY_IF on grant; stay in IDLE when no request.
  - BUSY_x → DONE on mem_ack.
  - DONE → IDLE unconditionally.
  - Requests are ignored in DONE.
- Grant rule in IDLE:
  - Only dm_req: grant data.
  - Only if_req: grant fetch.
  - Both, streak < MAX_DM_STREAK: grant data.
  - Both, streak == MAX_DM_STREAK: grant fetch.
- Streak counter:
  - Width $clog2(MAX_DM_STREAK+1), saturating.
  - Data grant with if_req=1: increment.
  - Data grant with if_req=0: clear.
  - Fetch grant: clear.
- On grant, address, we and wdata are latched into payload registers. Fetch forces mem_we=0 and mem_wdata=0.
- mem_addr, mem_we and mem_wdata are driven from the payload registers and stay stable throughout BUSY_x.
- On mem_ack, mem_rdata is captured into the granted requester's rdata register. The other requester's rdata is unchanged.
- Stores complete the same way. dm_valid pulses, and dm_rdata holds its previous value.

## Timing
- Reset values:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0.
  - state=IDLE, streak=0.
- All outputs are registered except stall_if and stall_dm.
- Cycle-level sequence, request sampled high in IDLE at edge N:
  - mem_req=1 from cycle N+1.
  - mem_ack sampled at edge M (earliest M = N+1): mem_req=0 and x_valid=1 in cycle M+1.
  - IDLE again in cycle M+2.
- Minimum request-to-valid latency is 2 cycles. Back-to-back throughput is one transaction per 3 cycles with zero-wait memory.
- Requester handshake: drop x_req at the edge where x_valid is seen. A request still high in the IDLE cycle after DONE counts as a new request.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction: next cycle state=IDLE, mem_req=0, no valid pulse. A later stale mem_ack is ignored.

## Structure
- core_pkg holds:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM, ARB_DONE} arb_state_t.
  - typedef enum logic {GNT_IF, GNT_DM} arb_gnt_t.
- Single module, no sub-modules. Streak counter and payload registers are inline.

## Test plan
- Lone fetch, if_addr=0x100, mem_ack in first mem_req cycle, mem_rdata=0xDEADBEEF → mem_req high one cycle with mem_addr=0x100 and mem_we=0; if_valid pulses 2 cycles after request with if_rdata=0xDEADBEEF.
- Simultaneous if_req and dm_req (store 0x55 to 0x200) → data first with mem_we=1 and mem_wdata=0x55; fetch issued after DONE; stall_if high throughout until if_valid.
- if_req held with dm_req continuously re-asserted, MAX_DM_STREAK=4 → exactly 4 data grants, then 1 fetch grant, with the streak cleared afterwards.
- mem_ack delayed 5 cycles → mem_req and payload stable for 6 cycles; single dm_valid pulse; dm_rdata captured from the ack cycle only.
- reset asserted during BUSY_DM, then mem_ack 2 cycles later → mem_req=0 the cycle after reset; no dm_valid; state IDLE; streak=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared types for the core's memory-side blocks.
package core_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_IF, ARB_BUSY_DM, ARB_DONE} arb_state_t;
  typedef enum logic {GNT_IF, GNT_DM} arb_gnt_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares the single memory port between instruction fetch and load/store,
// with data priority and a bounded data streak so fetch always progresses.
//
// state        | meaning
// ARB_IDLE     | no memory request outstanding, arbitrate
// ARB_BUSY_IF  | fetch transaction in flight
// ARB_BUSY_DM  | data transaction in flight
// ARB_DONE     | completion cycle, valid pulse out, requests ignored
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_if,
  output logic              stall_dm
);

  localparam int STREAK_W = $clog2(MAX_DM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DM_STREAK);

  arb_state_t          state_q, state_d;
  arb_gnt_t            gnt_sel;
  logic                grant;
  logic                ack_seen;
  logic [STREAK_W-1:0] streak_q;

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    gnt_sel = GNT_IF;
    case (state_q)
      ARB_IDLE: begin
        if (dm_req && (!if_req || streak_q < STREAK_MAX)) begin
          grant   = 1'b1;
          gnt_sel = GNT_DM;
          state_d = ARB_BUSY_DM;
        end else if (if_req) begin
          grant   = 1'b1;
          gnt_sel = GNT_IF;
          state_d = ARB_BUSY_IF;
        end
      end
      ARB_BUSY_IF, ARB_BUSY_DM: begin
        if (mem_ack) state_d = ARB_DONE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // mem_ack only matters while a request is actually on the port
  assign ack_seen = mem_ack && (state_q == ARB_BUSY_IF || state_q == ARB_BUSY_DM);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ARB_IDLE;
      streak_q  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state_q  <= state_d;
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      if (grant) begin
        mem_req <= 1'b1;
        if (gnt_sel == GNT_DM) begin
          mem_addr  <= dm_addr;
          mem_we    <= dm_we;
          mem_wdata <= dm_wdata;
          if (!if_req)                      streak_q <= '0;
          else if (streak_q != STREAK_MAX)  streak_q <= streak_q + 1'b1;
        end else begin
          mem_addr  <= if_addr;
          mem_we    <= 1'b0;
          mem_wdata <= '0;
          streak_q  <= '0;
        end
      end
      if (ack_seen) begin
        mem_req <= 1'b0;
        if (state_q == ARB_BUSY_IF) begin
          if_rdata <= mem_rdata;
          if_valid <= 1'b1;
        end else begin
          // stores leave the previous load data in place
          if (!mem_we) dm_rdata <= mem_rdata;
          dm_valid <= 1'b1;
        end
      end
    end
  end

  assign stall_if = if_req & ~if_valid;
  assign stall_dm = dm_req & ~dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: transaction-level model checked every
// cycle, plus literal expectations for latency, grant order and reset.
module tb_mem_port_arbiter;

  localparam int MAXS = 4;

  logic        clk, reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_if, stall_dm;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port, whether we are in the
  // completion cycle, and how many data wins fetch has had to sit through.
  int          m_owner = 0;   // 0 none, 1 fetch, 2 data
  bit          m_done  = 0;
  int          m_streak = 0;
  logic        m_mem_req = 0, m_we = 0, m_if_valid = 0, m_dm_valid = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_if_rdata = 0, m_dm_rdata = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_owner = 0; m_done = 0; m_streak = 0;
      m_mem_req = 0; m_we = 0; m_addr = 0; m_wdata = 0;
      m_if_valid = 0; m_dm_valid = 0; m_if_rdata = 0; m_dm_rdata = 0;
    end else begin
      m_if_valid = 0;
      m_dm_valid = 0;
      if (m_done) begin
        m_done = 0;
      end else if (m_owner != 0) begin
        if (mem_ack) begin
          if (m_owner == 1) begin
            m_if_valid = 1; m_if_rdata = mem_rdata;
          end else begin
            m_dm_valid = 1;
            if (!m_we) m_dm_rdata = mem_rdata;
          end
          m_owner = 0; m_done = 1; m_mem_req = 0;
        end
      end else if (dm_req && (!if_req || m_streak < MAXS)) begin
        m_owner = 2; m_mem_req = 1;
        m_streak = if_req ? m_streak + 1 : 0;
        m_addr = dm_addr; m_we = dm_we; m_wdata = dm_wdata;
      end else if (if_req) begin
        m_owner = 1; m_mem_req = 1; m_streak = 0;
        m_addr = if_addr; m_we = 0; m_wdata = 0;
      end
    end
  end

  bit   chk_en = 0;
  bit   ack_en = 1;
  int   ack_delay = 0;
  int   wait_cnt = 0;
  logic [31:0] ack_data = 0;
  int   if_left = 0, dm_left = 0;
  int   tick_no = 0;
  bit   prev_req = 0;
  bit   glog[$];   // 1 = data grant (dm address 0x200), 0 = anything else

  task automatic check_outputs();
    chk("mem_req",   mem_req,   m_mem_req);
    chk("mem_we",    mem_we,    m_we);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("if_valid",  if_valid,  m_if_valid);
    chk("dm_valid",  dm_valid,  m_dm_valid);
    chk("if_rdata",  if_rdata,  m_if_rdata);
    chk("dm_rdata",  dm_rdata,  m_dm_rdata);
    chk("stall_if",  stall_if,  if_req && !m_if_valid);
    chk("stall_dm",  stall_dm,  dm_req && !m_dm_valid);
  endtask

  task automatic tick();
    @(negedge clk);
    tick_no++;
    if (chk_en) check_outputs();
    if (mem_req === 1'b1 && !prev_req) glog.push_back(mem_addr == 32'h200);
    prev_req = (mem_req === 1'b1);
    // memory responder
    if (!ack_en) begin
      wait_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 0; wait_cnt = 0; mem_rdata = 32'hBAD0_0000 + tick_no;
    end else if (mem_req === 1'b1) begin
      if (wait_cnt == ack_delay) begin
        mem_ack = 1; mem_rdata = ack_data;
      end else begin
        wait_cnt++; mem_rdata = 32'hBAD0_0000 + tick_no;
      end
    end else begin
      wait_cnt = 0; mem_rdata = 32'hBAD0_0000 + tick_no;
    end
    // requesters: keep requesting while work remains, drop on the last valid
    if (if_valid === 1'b1 && if_left > 0) begin
      if_left--;
      if (if_left == 0) if_req = 0;
    end
    if (dm_valid === 1'b1 && dm_left > 0) begin
      dm_left--;
      if (dm_left == 0) dm_req = 0;
    end
  endtask

  task automatic chk_log(input string name, input string exp);
    chk({name, "_count"}, glog.size(), exp.len());
    for (int i = 0; i < exp.len() && i < glog.size(); i++)
      chk(name, glog[i], exp[i] == "1");
  endtask

  initial begin
    int t_valid, n_req, n_valid, stall_n, dm_t, if_t, n;
    logic [31:0] a1, w1, r1;
    logic        we1;

    reset = 1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    @(negedge clk);
    chk_en = 1;
    tick();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_valids", {if_valid, dm_valid}, 0);
    chk("rst_rdata", if_rdata | dm_rdata, 0);
    reset = 0;
    tick();

    // lone fetch, zero-wait memory
    glog.delete();
    ack_delay = 0; ack_data = 32'hDEADBEEF;
    if_addr = 32'h100; if_req = 1; if_left = 1;
    t_valid = 0; n_req = 0; a1 = 0; we1 = 1; r1 = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 1) begin a1 = mem_addr; we1 = mem_we; end
      if (mem_req) n_req++;
      if (if_valid && t_valid == 0) begin t_valid = t; r1 = if_rdata; end
    end
    chk("t1_latency", t_valid, 2);
    chk("t1_req_cycles", n_req, 1);
    chk("t1_addr", a1, 32'h100);
    chk("t1_we", we1, 0);
    chk("t1_rdata", r1, 32'hDEADBEEF);

    // simultaneous store and fetch: data first
    glog.delete();
    ack_data = 32'h0000_1234;
    if_addr = 32'h104; if_req = 1; if_left = 1;
    dm_addr = 32'h200; dm_we = 1; dm_wdata = 32'h55; dm_req = 1; dm_left = 1;
    dm_t = 0; if_t = 0; stall_n = 0; we1 = 0; w1 = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (t == 1) begin we1 = mem_we; w1 = mem_wdata; end
      if (dm_valid && dm_t == 0) dm_t = t;
      if (if_valid && if_t == 0) if_t = t;
      if (if_t == 0 && stall_if) stall_n++;
    end
    chk("t2_store_we", we1, 1);
    chk("t2_store_wdata", w1, 32'h55);
    chk("t2_dm_valid_at", dm_t, 2);
    chk("t2_if_valid_at", if_t, 5);
    chk("t2_stall_if_cycles", stall_n, 4);
    chk("t2_dm_rdata_held", dm_rdata, 0);
    chk_log("t2_order", "10");

    // fetch held against continuous loads: bounded streak
    glog.delete();
    dm_we = 0; dm_wdata = 0; ack_data = 32'h0000_0A0A;
    if_addr = 32'h100; if_req = 1; if_left = 2;
    dm_addr = 32'h200; dm_req = 1; dm_left = 8;
    for (int t = 1; t <= 40; t++) tick();
    chk_log("t3_streak", "1111011110");

    // delayed ack on a load
    glog.delete();
    ack_delay = 5; ack_data = 32'hCAFE0004;
    dm_addr = 32'h300; dm_we = 0; dm_req = 1; dm_left = 1;
    n_req = 0; n_valid = 0; r1 = 0;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (mem_req) n_req++;
      if (dm_valid) begin n_valid++; r1 = dm_rdata; end
    end
    chk("t4_req_cycles", n_req, 6);
    chk("t4_valid_pulses", n_valid, 1);
    chk("t4_rdata", r1, 32'hCAFE0004);

    // reset in the middle of a data transaction that built up a streak
    glog.delete();
    ack_delay = 3; ack_data = 32'h0000_0BBB;
    if_addr = 32'h100; if_req = 1; if_left = 1;
    dm_addr = 32'h200; dm_req = 1; dm_left = 10;
    n = 0;
    while (glog.size() < 3 && n < 60) begin tick(); n++; end
    chk("t5_setup_grants", glog.size(), 3);
    ack_en = 0; mem_ack = 0;
    reset = 1; if_req = 0; dm_req = 0; if_left = 0; dm_left = 0;
    tick();
    chk("t5_req_after_rst", mem_req, 0);
    chk("t5_valid_after_rst", dm_valid, 0);
    reset = 0;
    tick();
    mem_ack = 1; mem_rdata = 32'h77;
    tick();
    mem_ack = 0;
    n_req = 0; n_valid = 0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (mem_req) n_req++;
      if (dm_valid || if_valid) n_valid++;
    end
    chk("t5_stale_ack_req", n_req, 0);
    chk("t5_stale_ack_valid", n_valid, 0);
    chk("t5_stale_ack_rdata", dm_rdata, 0);
    // streak must restart from zero: four data wins before fetch
    glog.delete();
    ack_en = 1; ack_delay = 0;
    if_req = 1; if_left = 1;
    dm_req = 1; dm_left = 5;
    for (int t = 1; t <= 30; t++) tick();
    chk_log("t5_streak_cleared", "111101");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
